// File: rtl/cpu_types_pkg.sv
// Shared CPU board-test types: ALU opcodes, operand-entry FSM states and
// the switch sign-fill helper used by the operand sequencer.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_OR  = 4'h1,
        ALU_ADD = 4'h2,
        ALU_SUB = 4'h6,
        ALU_SLT = 4'h7,
        ALU_NOR = 4'hC
    } aluop_t;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        SHOW    = 2'd3
    } seq_state_t;

    // SW[16] selects the upper half fill, SW[15:0] is the literal value
    function automatic logic [31:0] ext_sw(input logic [16:0] sw);
        return {sw[16] ? 16'hFFFF : 16'h0000, sw[15:0]};
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_key_debounce.sv
// key_debounce: synchronises one raw active-low button, accepts a level
// change only after DEBOUNCE_CYCLES stable cycles, and emits a single-cycle
// pulse on an accepted press (never on release).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RST,
    input  logic key_n,
    output logic pressed_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1, sync2;
    logic          accepted;   // accepted raw level, 1 = released
    logic [CW-1:0] cnt;

    // Two-flop synchroniser, idles at the released level
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Stability counter; any return to the accepted level restarts it
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            cnt           <= '0;
            accepted      <= 1'b1;
            pressed_pulse <= 1'b0;
        end else begin
            pressed_pulse <= 1'b0;
            if (sync2 == accepted) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                accepted      <= sync2;
                cnt           <= '0;
                pressed_pulse <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced enter/cancel buttons step a four-state
// entry FSM that loads operand A, operand B and the opcode from SW, then
// snapshots the ALU result and flags for the display.
// Optional feature macro: ACC_CHAIN_EN (enter in SHOW feeds the result back
// into operand A and resumes at LOAD_B).
module alu_operand_sequencer
    import cpu_types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = 32
) (
    input  logic              CLOCK_50,
    input  logic              RST,
    input  logic [1:0]        key_n,
    input  logic [16:0]       sw,
    input  logic [DATA_W-1:0] result_in,
    input  logic [2:0]        flags_in,
    output logic [DATA_W-1:0] porta,
    output logic [DATA_W-1:0] portb,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] disp_value,
    output logic [2:0]        disp_flags,
    output logic              res_valid,
    output logic [1:0]        state_o
);
    seq_state_t        state;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] sw_ext;
    logic              enter, cancel;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .CLOCK_50      (CLOCK_50),
        .RST           (RST),
        .key_n         (key_n[0]),
        .pressed_pulse (enter)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .CLOCK_50      (CLOCK_50),
        .RST           (RST),
        .key_n         (key_n[1]),
        .pressed_pulse (cancel)
    );

    assign sw_ext  = DATA_W'(ext_sw(sw));
    assign state_o = state;

    // Entry FSM; cancel has priority, and the first SHOW cycle (res_valid
    // still low) takes the result snapshot
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state      <= LOAD_A;
            porta      <= '0;
            portb      <= '0;
            alu_op     <= '0;
            result_q   <= '0;
            disp_flags <= '0;
            res_valid  <= 1'b0;
        end else if (cancel) begin
            state     <= LOAD_A;
            res_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (enter) begin
                    porta <= sw_ext;
                    state <= LOAD_B;
                end
                LOAD_B: if (enter) begin
                    portb <= sw_ext;
                    state <= LOAD_OP;
                end
                LOAD_OP: if (enter) begin
                    alu_op    <= sw[3:0];
                    res_valid <= 1'b0;
                    state     <= SHOW;
                end
                SHOW: begin
                    if (enter) begin
                        res_valid <= 1'b0;
`ifdef ACC_CHAIN_EN
                        porta     <= result_q;
                        state     <= LOAD_B;
`else
                        state     <= LOAD_A;
`endif
                    end else if (!res_valid) begin
                        result_q   <= result_in;
                        disp_flags <= flags_in;
                        res_valid  <= 1'b1;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    // Display mux: live switch value while entering, snapshot once shown
    always_comb begin
        disp_value = '0;
        case (state)
            LOAD_A, LOAD_B: disp_value = sw_ext;
            LOAD_OP:        disp_value = DATA_W'(sw[3:0]);
            SHOW:           disp_value = res_valid ? result_q : '0;
            default:        disp_value = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a short debounce window and
// a behavioural ALU closing the porta/portb/alu_op -> result_in loop.
module tb_alu_operand_sequencer;
    localparam int D = 4;
    localparam int W = 32;

    logic          CLOCK_50 = 1'b0;
    logic          RST      = 1'b1;
    logic [1:0]    key_n    = 2'b11;
    logic [16:0]   sw       = '0;
    logic [W-1:0]  result_in;
    logic [2:0]    flags_in;
    logic [W-1:0]  porta, portb, disp_value;
    logic [3:0]    alu_op;
    logic [2:0]    disp_flags;
    logic          res_valid;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(D), .DATA_W(W)) dut (
        .CLOCK_50   (CLOCK_50),
        .RST        (RST),
        .key_n      (key_n),
        .sw         (sw),
        .result_in  (result_in),
        .flags_in   (flags_in),
        .porta      (porta),
        .portb      (portb),
        .alu_op     (alu_op),
        .disp_value (disp_value),
        .disp_flags (disp_flags),
        .res_valid  (res_valid),
        .state_o    (state_o)
    );

    // Behavioural ALU: {neg, ovf, zero}
    always_comb begin
        logic ovf;
        ovf       = 1'b0;
        result_in = '0;
        case (alu_op)
            4'h0: result_in = porta & portb;
            4'h1: result_in = porta | portb;
            4'h2: begin
                result_in = porta + portb;
                ovf = (porta[31] == portb[31]) && (result_in[31] != porta[31]);
            end
            4'h6: begin
                result_in = porta - portb;
                ovf = (porta[31] != portb[31]) && (result_in[31] != porta[31]);
            end
            default: result_in = '0;
        endcase
        flags_in = {result_in[31], ovf, result_in == '0};
    end

    task automatic do_reset();
        @(negedge CLOCK_50);
        RST   = 1'b1;
        key_n = 2'b11;
        repeat (2) @(negedge CLOCK_50);
        RST = 1'b0;
        @(negedge CLOCK_50);
    endtask

    // Press the masked keys long enough to be accepted, then release and settle
    task automatic press(input logic [1:0] mask);
        @(negedge CLOCK_50);
        key_n = ~mask;
        repeat (12) @(negedge CLOCK_50);
        key_n = 2'b11;
        repeat (12) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (porta !== 32'h0 || portb !== 32'h0 || alu_op !== 4'h0) begin
            errors++;
            $display("FAIL reset_operands: got a=%h b=%h op=%h, expected 0/0/0", porta, portb, alu_op);
        end
        checks++;
        if (state_o !== 2'd0 || res_valid !== 1'b0 || disp_flags !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got st=%0d rv=%b fl=%b, expected 0/0/000", state_o, res_valid, disp_flags);
        end
        sw = 17'h1_0012;
        #1;
        checks++;
        if (disp_value !== 32'hFFFF_0012) begin
            errors++;
            $display("FAIL disp_load_a: got %h, expected ffff0012", disp_value);
        end
    endtask

    task automatic test_basic_add();
        int lat;
        sw = 17'h0_0005;
        @(negedge CLOCK_50);
        key_n = 2'b10;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge CLOCK_50);
            if (state_o == 2'd1) lat = i;
        end
        checks++;
        if (lat != D + 4) begin
            errors++;
            $display("FAIL enter_latency: got %0d negedges, expected %0d", lat, D + 4);
        end
        key_n = 2'b11;
        repeat (12) @(negedge CLOCK_50);
        checks++;
        if (porta !== 32'h5 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL load_a: got a=%h st=%0d, expected 5/1", porta, state_o);
        end
        sw = 17'h0_0003;
        press(2'b01);
        checks++;
        if (portb !== 32'h3 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL load_b: got b=%h st=%0d, expected 3/2", portb, state_o);
        end
        sw = 17'h1_FFF2;
        #1;
        checks++;
        if (disp_value !== 32'h2) begin
            errors++;
            $display("FAIL disp_load_op: got %h, expected 2", disp_value);
        end
        @(negedge CLOCK_50);
        key_n = 2'b10;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge CLOCK_50);
            if (state_o == 2'd3) lat = i;
        end
        checks++;
        if (lat == 0 || res_valid !== 1'b0 || disp_value !== 32'h0) begin
            errors++;
            $display("FAIL show_entry: got lat=%0d rv=%b disp=%h, expected rv=0 disp=0", lat, res_valid, disp_value);
        end
        @(negedge CLOCK_50);
        checks++;
        if (res_valid !== 1'b1 || disp_value !== 32'h8 || disp_flags !== 3'b000 || alu_op !== 4'h2) begin
            errors++;
            $display("FAIL show_result: got rv=%b disp=%h fl=%b op=%h, expected 1/8/000/2",
                     res_valid, disp_value, disp_flags, alu_op);
        end
        key_n = 2'b11;
        repeat (12) @(negedge CLOCK_50);
        checks++;
        if (state_o !== 2'd3 || disp_value !== 32'h8) begin
            errors++;
            $display("FAIL show_hold: got st=%0d disp=%h, expected 3/8", state_o, disp_value);
        end
    endtask

    task automatic test_acc_chain();
        press(2'b01);
`ifdef ACC_CHAIN_EN
        checks++;
        if (porta !== 32'h8 || state_o !== 2'd1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL acc_chain: got a=%h st=%0d rv=%b, expected 8/1/0", porta, state_o, res_valid);
        end
`else
        checks++;
        if (porta !== 32'h5 || state_o !== 2'd0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL show_exit: got a=%h st=%0d rv=%b, expected 5/0/0", porta, state_o, res_valid);
        end
`endif
    endtask

    task automatic test_sign_fill();
        do_reset();
        sw = 17'h1_8000;
        press(2'b01);
        checks++;
        if (porta !== 32'hFFFF_8000 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL sign_fill: got a=%h st=%0d, expected ffff8000/1", porta, state_o);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        sw = 17'h0_0077;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            key_n[0] = ~key_n[0];
            @(negedge CLOCK_50);
        end
        key_n = 2'b11;
        repeat (15) @(negedge CLOCK_50);
        checks++;
        if (state_o !== 2'd0 || porta !== 32'h0) begin
            errors++;
            $display("FAIL bounce: got st=%0d a=%h, expected 0/0", state_o, porta);
        end
    endtask

    task automatic test_hold();
        do_reset();
        sw = 17'h0_0009;
        @(negedge CLOCK_50);
        key_n = 2'b10;
        repeat (40) @(negedge CLOCK_50);
        key_n = 2'b11;
        repeat (12) @(negedge CLOCK_50);
        checks++;
        if (state_o !== 2'd1 || porta !== 32'h9) begin
            errors++;
            $display("FAIL held_key: got st=%0d a=%h, expected 1/9", state_o, porta);
        end
    endtask

    task automatic test_collision();
        do_reset();
        sw = 17'h0_0007; press(2'b01);
        sw = 17'h0_0004; press(2'b01);
        sw = 17'h0_0006; press(2'b01);   // SUB: 7-4
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (res_valid !== 1'b1 || disp_value !== 32'h3 || alu_op !== 4'h6) begin
            errors++;
            $display("FAIL sub_result: got rv=%b disp=%h op=%h, expected 1/3/6", res_valid, disp_value, alu_op);
        end
        press(2'b10);                    // cancel from SHOW
        checks++;
        if (state_o !== 2'd0 || res_valid !== 1'b0 || porta !== 32'h7) begin
            errors++;
            $display("FAIL cancel_show: got st=%0d rv=%b a=%h, expected 0/0/7", state_o, res_valid, porta);
        end
        press(2'b01);
        press(2'b01);
        sw = 17'h0_0002;
        press(2'b11);                    // enter+cancel together in LOAD_OP
        checks++;
        if (state_o !== 2'd0 || alu_op !== 4'h6 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL collision: got st=%0d op=%h rv=%b, expected 0/6/0", state_o, alu_op, res_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        sw = 17'h0_0005;
        press(2'b01);
        checks++;
        if (porta !== 32'h5 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset: got a=%h st=%0d, expected 5/1", porta, state_o);
        end
        @(negedge CLOCK_50);
        RST = 1'b1;
        #1;
        checks++;
        if (porta !== 32'h0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got a=%h st=%0d, expected 0/0", porta, state_o);
        end
        @(negedge CLOCK_50);
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_acc_chain();
        test_sign_fill();
        test_bounce();
        test_hold();
        test_collision();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
